// File: rtl/out_port_scheduler_pkg.sv
// ============================================================================
// out_port_scheduler_pkg -- shared widths, config field offsets, reset values
// Revision: 1.0
// ============================================================================
`default_nettype none

package out_port_scheduler_pkg;

    localparam int DEF_PACKET_BITS   = 97;
    localparam int DEF_NUM_LEAF_BITS = 6;
    localparam int DEF_NUM_PORT_BITS = 4;
    localparam int DEF_NUM_ADDR_BITS = 7;
    localparam int DEF_PAYLOAD_BITS  = 64;
    localparam int DEF_NUM_OUT_PORTS = 7;

    localparam int CRED_RESET_VAL  = 127;
    localparam int WADDR_RESET_VAL = 0;

    // Slice layout, LSB first: freespace, bram_addr, dst_port, dst_leaf, add, upd_bram, upd_free
    function automatic int cfg_bram_lsb(input int addr_bits);
        return addr_bits;
    endfunction

    function automatic int cfg_port_lsb(input int addr_bits);
        return 2 * addr_bits;
    endfunction

    function automatic int cfg_leaf_lsb(input int addr_bits, input int port_bits);
        return 2 * addr_bits + port_bits;
    endfunction

    function automatic int cfg_add_bit(input int addr_bits, input int port_bits, input int leaf_bits);
        return 2 * addr_bits + port_bits + leaf_bits;
    endfunction

    function automatic int cfg_bits(input int leaf_bits, input int port_bits, input int addr_bits);
        return leaf_bits + port_bits + 2 * addr_bits + 3;
    endfunction

    function automatic int fifo_addr_bits(input int packet_bits, input int leaf_bits,
                                          input int port_bits, input int payload_bits);
        return packet_bits - 1 - leaf_bits - port_bits - payload_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/out_port_scheduler_rr_arbiter.sv
// ============================================================================
// rr_arbiter -- one-hot round-robin grant, search starts after last winner
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] grant
);

    localparam int PTR_BITS = (N > 1) ? $clog2(N) : 1;

    logic [PTR_BITS-1:0] last;
    logic [PTR_BITS-1:0] idx;
    logic [PTR_BITS-1:0] winner;
    logic                found;

    always_comb begin
        grant  = '0;
        found  = 1'b0;
        winner = last;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PTR_BITS'((int'(last) + k) % N);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = idx;
                found      = 1'b1;
            end
        end
    end

    // Reset to the last port so the first search begins at port 0
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= PTR_BITS'(N - 1);
        end else if (found) begin
            last <= winner;
        end
    end

endmodule

`default_nettype wire

// File: rtl/out_port_scheduler.sv
// ============================================================================
// out_port_scheduler -- credit-gated round-robin merge of ports onto one link
// Revision: 1.0
// ============================================================================
`default_nettype none

module out_port_scheduler
    import out_port_scheduler_pkg::*;
#(
    parameter int PACKET_BITS   = DEF_PACKET_BITS,
    parameter int NUM_LEAF_BITS = DEF_NUM_LEAF_BITS,
    parameter int NUM_PORT_BITS = DEF_NUM_PORT_BITS,
    parameter int NUM_ADDR_BITS = DEF_NUM_ADDR_BITS,
    parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
    parameter int NUM_OUT_PORTS = DEF_NUM_OUT_PORTS
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic [cfg_bits(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS)*NUM_OUT_PORTS-1:0] out_cfg,
    input  logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0]                        din,
    input  logic [NUM_OUT_PORTS-1:0]                                     din_valid,
    output logic [NUM_OUT_PORTS-1:0]                                     din_ready,
    output logic [PACKET_BITS-1:0]                                       dout,
    output logic                                                         dout_valid,
    input  logic                                                         dout_ready
);

    localparam int FIFO_ADDR_BITS = fifo_addr_bits(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS);
    localparam int CFG_BITS       = cfg_bits(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS);
    localparam int BRAM_LSB       = cfg_bram_lsb(NUM_ADDR_BITS);
    localparam int PORT_LSB       = cfg_port_lsb(NUM_ADDR_BITS);
    localparam int LEAF_LSB       = cfg_leaf_lsb(NUM_ADDR_BITS, NUM_PORT_BITS);
    localparam int ADD_BIT        = cfg_add_bit(NUM_ADDR_BITS, NUM_PORT_BITS, NUM_LEAF_BITS);
    localparam int UPD_BRAM_BIT   = ADD_BIT + 1;
    localparam int UPD_FREE_BIT   = ADD_BIT + 2;
    localparam logic [NUM_ADDR_BITS-1:0] CRED_MAX = '1;

    logic [NUM_ADDR_BITS-1:0] cred      [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] waddr     [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] freespace [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] bram_addr [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] dst_leaf  [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dst_port  [NUM_OUT_PORTS];
    logic [CFG_BITS-1:0]      cfg_slice;
    logic [NUM_OUT_PORTS-1:0] upd_free;
    logic [NUM_OUT_PORTS-1:0] upd_bram;
    logic [NUM_OUT_PORTS-1:0] add_free;
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic [NUM_OUT_PORTS-1:0] send;
    logic [PACKET_BITS-1:0]   next_pkt;
    logic                     slot_free;

    always_comb begin
        cfg_slice = '0;
        upd_free  = '0;
        upd_bram  = '0;
        add_free  = '0;
        eligible  = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            cfg_slice    = out_cfg[CFG_BITS*i +: CFG_BITS];
            freespace[i] = cfg_slice[0 +: NUM_ADDR_BITS];
            bram_addr[i] = cfg_slice[BRAM_LSB +: NUM_ADDR_BITS];
            dst_port[i]  = cfg_slice[PORT_LSB +: NUM_PORT_BITS];
            dst_leaf[i]  = cfg_slice[LEAF_LSB +: NUM_LEAF_BITS];
            add_free[i]  = cfg_slice[ADD_BIT];
            upd_bram[i]  = cfg_slice[UPD_BRAM_BIT];
            upd_free[i]  = cfg_slice[UPD_FREE_BIT];
            eligible[i]  = din_valid[i] && (cred[i] != '0) && !upd_free[i] && !upd_bram[i];
        end
    end

    // Grants are suppressed during reset so din_ready reads 0 there
    assign slot_free = !dout_valid || dout_ready;

    rr_arbiter #(
        .N      (NUM_OUT_PORTS)
    ) u_rr_arbiter (
        .clk    (clk),
        .reset  (reset),
        .req    (eligible),
        .enable (slot_free && !reset),
        .grant  (grant)
    );

    assign din_ready = grant;
    assign send      = din_valid & grant;

    always_comb begin
        next_pkt = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (send[i]) begin
                next_pkt = {1'b1, dst_leaf[i], dst_port[i], FIFO_ADDR_BITS'(waddr[i]),
                            din[PAYLOAD_BITS*i +: PAYLOAD_BITS]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                cred[i]  <= NUM_ADDR_BITS'(CRED_RESET_VAL);
                waddr[i] <= NUM_ADDR_BITS'(WADDR_RESET_VAL);
            end
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (upd_free[i]) begin
                    cred[i] <= freespace[i];
                end else if (add_free[i] && !send[i]) begin
                    if (cred[i] != CRED_MAX) begin
                        cred[i] <= cred[i] + 1'b1;
                    end
                end else if (send[i] && !add_free[i]) begin
                    cred[i] <= cred[i] - 1'b1;
                end

                if (upd_bram[i]) begin
                    waddr[i] <= bram_addr[i];
                end else if (send[i]) begin
                    waddr[i] <= waddr[i] + 1'b1;
                end
            end
        end
    end

    // Output register only reloads when the slot is free, so a stalled packet holds
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (slot_free) begin
            dout       <= next_pkt;
            dout_valid <= |send;
        end
    end

endmodule

`default_nettype wire
